// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues reads to the synchronous Memory, and queues {pc, word} in an in-order prefetch FIFO.
// Two-cycle fetch latency; a FIFO slot is reserved before a read issues, so a returning word always finds space.
module fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_enable,
  input  logic              mem_grant,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemOut,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic              pending_q, pending_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0] fifo_dat_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q  [DEPTH];
  logic [CNT_W:0]    occupancy;
  logic              issue, push, pop;

  // The in-flight read counts as occupied so its response can never overflow.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
  assign issue     = reset_n & fetch_enable & mem_grant & ~redirect_valid & (occupancy < DEPTH_OCC);
  assign push      = pending_q & ~redirect_valid;
  assign pop       = instr_valid & instr_ready & ~redirect_valid;

  assign MemRead     = issue;
  assign MemAddr     = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_dat_q[rd_ptr_q] : hold_instr_q;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]  : hold_pc_q;

  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pending_d    = issue;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    hold_instr_d = instr;
    hold_pc_d    = instr_pc;
    if (issue) begin
      pc_d      = pc_q + PC_ONE;
      pend_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      pending_d = 1'b0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= '0;
      pend_pc_q    <= '0;
      pending_q    <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pending_q    <= pending_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Entry payload needs no reset: it is only visible while count_q says it is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_dat_q[wr_ptr_q] <= MemOut;
      fifo_pc_q[wr_ptr_q]  <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 256-word synchronous memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_enable = 1'b1;
  logic        mem_grant = 1'b1;
  logic        MemRead;
  logic [15:0] MemAddr;
  logic [15:0] MemOut = 16'h0000;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  fetch_unit #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .fetch_enable(fetch_enable), .mem_grant(mem_grant),
    .MemRead(MemRead), .MemAddr(MemAddr), .MemOut(MemOut),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (MemRead) MemOut <= mem[MemAddr[7:0]];
  end

  typedef struct {
    bit          rst;
    bit          en, gnt, rdy, rv;
    logic [15:0] rpc;
    bit          e_rd;
    logic [15:0] e_addr;
    bit          e_vld;
    logic [15:0] e_instr, e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit en, bit gnt, bit rdy, bit rv, logic [15:0] rpc,
                             bit e_rd, logic [15:0] e_addr, bit e_vld,
                             logic [15:0] e_instr, logic [15:0] e_pc);
    vec_t r;
    r.rst = rst; r.en = en; r.gnt = gnt; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.e_rd = e_rd; r.e_addr = e_addr; r.e_vld = e_vld; r.e_instr = e_instr; r.e_pc = e_pc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read 1ns later.
  task automatic drive(input bit rst, input bit en, input bit gnt, input bit rdy,
                       input bit rv, input logic [15:0] rpc);
    @(negedge clock);
    if (rst) begin
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
    end
    fetch_enable = en; mem_grant = gnt; instr_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic chk_all(input string tag, input bit rd, input logic [15:0] addr,
                         input bit vld, input logic [15:0] ins, input logic [15:0] pc);
    chk({tag, " MemRead"},     {15'd0, MemRead},     {15'd0, rd});
    chk({tag, " MemAddr"},     MemAddr,              addr);
    chk({tag, " instr_valid"}, {15'd0, instr_valid}, {15'd0, vld});
    chk({tag, " instr"},       instr,                ins);
    chk({tag, " instr_pc"},    instr_pc,             pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    // Streaming from reset with consumer always ready.
    tbl.push_back(v(1,1,1,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0001, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0002, 1,16'h1111,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0003, 1,16'h2222,16'h0001));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0004, 1,16'h3333,16'h0002));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0005, 1,16'h4444,16'h0003));
    // Consumer stalled: four reads fill the FIFO, then drain in order.
    tbl.push_back(v(1,1,1,0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,0,0,16'h0000, 1,16'h0001, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,0,0,16'h0000, 1,16'h0002, 1,16'h1111,16'h0000));
    tbl.push_back(v(0,1,1,0,0,16'h0000, 1,16'h0003, 1,16'h1111,16'h0000));
    tbl.push_back(v(0,1,1,0,0,16'h0000, 0,16'h0004, 1,16'h1111,16'h0000));
    tbl.push_back(v(0,1,1,0,0,16'h0000, 0,16'h0004, 1,16'h1111,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 0,16'h0004, 1,16'h1111,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0004, 1,16'h2222,16'h0001));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0005, 1,16'h3333,16'h0002));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0006, 1,16'h4444,16'h0003));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0007, 1,16'hA504,16'h0004));
    // Grant alternating: no reads without grant, outputs hold while empty.
    tbl.push_back(v(1,1,1,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,0,1,0,16'h0000, 0,16'h0001, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0001, 1,16'h1111,16'h0000));
    tbl.push_back(v(0,1,0,1,0,16'h0000, 0,16'h0002, 0,16'h1111,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0002, 1,16'h2222,16'h0001));
    tbl.push_back(v(0,1,0,1,0,16'h0000, 0,16'h0003, 0,16'h2222,16'h0001));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0003, 1,16'h3333,16'h0002));
    // Held redirect tracks its pc; fetch across the 0xFFFF wrap.
    tbl.push_back(v(1,1,1,1,1,16'h0010, 0,16'h0000, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,1,1,16'hFFFF, 0,16'h0010, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'hFFFF, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0001, 1,16'hA5FF,16'hFFFF));
    tbl.push_back(v(0,1,1,1,0,16'h0000, 1,16'h0002, 1,16'h1111,16'h0000));

    // Outputs are forced low while reset is held, even with fetch enabled.
    #3;
    chk_all("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].gnt, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk_all($sformatf("row%0d", i), tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_vld,
              tbl[i].e_instr, tbl[i].e_pc);
    end

    // Redirect with two queued entries and one read in flight.
    drive(1, 1,1,0, 0,16'h0000);
    drive(0, 1,1,0, 0,16'h0000);
    drive(0, 1,1,0, 0,16'h0000);
    drive(0, 1,1,0, 1,16'h0040);
    chk("redir issue blocked", {15'd0, MemRead}, 16'h0000);
    chk("redir fifo held",     {15'd0, instr_valid}, 16'h0001);
    drive(0, 1,1,1, 0,16'h0000);
    chk_all("redir c1", 1'b1, 16'h0040, 1'b0, 16'h1111, 16'h0000);
    drive(0, 1,1,1, 0,16'h0000);
    chk_all("redir c2", 1'b1, 16'h0041, 1'b0, 16'h1111, 16'h0000);
    drive(0, 1,1,1, 0,16'h0000);
    chk_all("redir c3", 1'b1, 16'h0042, 1'b1, 16'hA540, 16'h0040);
    drive(0, 1,1,1, 0,16'h0000);
    chk_all("redir c4", 1'b1, 16'h0043, 1'b1, 16'hA541, 16'h0041);

    // Reset asserted mid-stream with a read pending.
    drive(1, 1,1,1, 0,16'h0000);
    drive(0, 1,1,1, 0,16'h0000);
    drive(0, 1,1,1, 0,16'h0000);
    chk("midrst pre valid", {15'd0, instr_valid}, 16'h0001);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all("midrst async", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(negedge clock);
    #1;
    chk_all("midrst held", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    reset_n = 1'b1;
    #1;
    chk_all("midrst c0", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    drive(0, 1,1,1, 0,16'h0000);
    chk_all("midrst c1", 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000);
    drive(0, 1,1,1, 0,16'h0000);
    chk_all("midrst c2", 1'b1, 16'h0002, 1'b1, 16'h1111, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the 16-bit word-addressed Memory block (synchronous read, data valid the cycle after MemRead is sampled). It owns the fetch PC and issues read requests to Memory when the top level grants it the memory port. It captures each returned word into a small in-order prefetch FIFO tagged with its PC, and hands instructions to the control/decode stage over a valid/ready handshake. A redirect input flushes everything in flight for branches and jumps.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
ADDR_W, 16, fetch address width (word address)
DATA_W, 16, instruction word width

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
fetch_enable  input  1  1 = may issue new reads; 0 = stop issuing, in-flight read still completes
mem_grant  input  1  1 = Memory port available to fetch this cycle (0 = data access owns it)
MemRead  output  1  read request to Memory, sampled at next rising edge
MemAddr  output  ADDR_W  read address to Memory (drives MemIn when granted)
MemOut  input  DATA_W  Memory read data, valid in the cycle after a sampled MemRead
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address
instr_valid  output  1  FIFO head valid
instr  output  DATA_W  instruction word at FIFO head
instr_pc  output  ADDR_W  address of instr
instr_ready  input  1  consumer accepts head this cycle

Behaviour:
- Reset (async, reset_n=0): pc=0, pending=0, FIFO empty. MemRead=0, MemAddr=0, instr_valid=0, instr=0, instr_pc=0 immediately and held while reset_n=0.
- Issue condition (combinational): issue = fetch_enable & mem_grant & ~redirect_valid & (count + pending < DEPTH). MemRead=issue; MemAddr=pc at all times.
- On an edge with issue=1: pending<=1, pend_pc<=pc, pc<=pc+1 (mod 2^ADDR_W; 0xFFFF wraps to 0x0000).
- Response: on the edge after an issue, pending=1 means MemOut is valid; push {pend_pc, MemOut} into FIFO. pending<=issue (back-to-back issue sustains 1 instr/cycle).
- Latency: request sampled at edge E1; instr_valid=1 with that word after edge E2, provided FIFO was empty.
- Pop: instr_valid & instr_ready at an edge removes head. Push and pop on the same edge are both honoured; count is unchanged.
- Credit is conservative: occupancy = count + pending, no credit taken for a same-cycle pop, so a push never finds the FIFO full. Overflow is impossible by construction. Underflow: pop with instr_valid=0 is ignored.
- instr/instr_pc are the FIFO head. When empty, they hold their last value and instr_valid=0.
- Redirect (priority over everything): on an edge with redirect_valid=1, FIFO is emptied, pending<=0 (the in-flight response is discarded, never pushed), pc<=redirect_pc, and no issue occurs that cycle. Any pop in that cycle is void. Next cycle may issue redirect_pc.
- Redirect held multiple cycles: fetch stays stalled, pc tracks redirect_pc each edge.
- fetch_enable=0 or mem_grant=0: no MemRead. An already-pending response is still captured on the next edge.
- Memory holds only 256 words. MemAddr carries the full ADDR_W bits; truncation is the top level's concern.
- Order is strictly in program order. No instruction is duplicated or skipped except across a redirect.

Test Plan:
- Memory[0..3]=0x1111,0x2222,0x3333,0x4444; release reset with enable=grant=ready=1 -> MemRead=1, MemAddr=0 in first cycle; instr_valid=1, instr=0x1111, instr_pc=0 after second edge; then 0x2222, 0x3333, 0x4444 on consecutive cycles.
- ready=0 from start -> exactly 4 reads issued (addr 0..3), then MemRead=0 while head holds 0x1111/pc 0. Raise ready -> 4 words drain in order; next issue is MemAddr=4.
- mem_grant toggles 1,0,1,0 -> MemRead=0 in every grant=0 cycle; delivered sequence is still pc 0,1,2,... with no gaps or repeats.
- With FIFO holding 2 entries and one read pending, pulse redirect_valid with redirect_pc=0x0040 -> next cycle instr_valid=0, MemAddr=0x0040. Pending word is never delivered; first delivered instr_pc=0x0040.
- Redirect to 0xFFFF -> issued addresses 0xFFFF then 0x0000; delivered instr_pc 0xFFFF then 0x0000.
- Assert reset_n=0 mid-stream with a read pending -> MemRead, instr_valid and all outputs 0 immediately. After release, fetch restarts at MemAddr=0 with no stale data delivered.
